// File: rtl/uart_cmd_frame_decoder.sv
// UART command frame decoder: turns the received byte stream into framed host
// commands (SYNC, OPCODE, LEN, PAYLOAD[LEN], CHK) presented on valid/ready.
module uart_cmd_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hFE,
    parameter int unsigned MAX_PAYLOAD  = 8,
    parameter int unsigned TIMEOUT_CLKS = 34720,
    parameter bit          LEGACY_SHORT = 1'b1,
    localparam int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_opcode,
    output logic [LEN_W-1:0]         cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     err_checksum,
    output logic                     err_length,
    output logic                     err_timeout,
    output logic                     err_overrun,
    output logic                     busy
);

    localparam int unsigned PL_W  = 8 * MAX_PAYLOAD;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_LEN,
        S_PAY,
        S_CHK,
        S_HOLD
    } state_t;

    state_t           state_q,   state_d;
    logic [7:0]       opcode_q,  opcode_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [PL_W-1:0]  payload_q, payload_d;
    logic [7:0]       xor_q,     xor_d;
    logic [LEN_W-1:0] idx_q,     idx_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic             err_chk_d, err_len_d, err_tmo_d, err_ovr_d;

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            len_q        <= '0;
            payload_q    <= '0;
            xor_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            cmd_valid    <= 1'b0;
            busy         <= 1'b0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            len_q        <= len_d;
            payload_q    <= payload_d;
            xor_q        <= xor_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            cmd_valid    <= (state_d == S_HOLD);
            busy         <= (state_d != S_IDLE);
            err_checksum <= err_chk_d;
            err_length   <= err_len_d;
            err_timeout  <= err_tmo_d;
            err_overrun  <= err_ovr_d;
        end
    end

    // Next-state, datapath update and error detection.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        len_d     = len_q;
        payload_d = payload_q;
        xor_d     = xor_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    state_d   = S_OPC;
                    payload_d = '0;
                    idx_d     = '0;
                end
            end

            S_HOLD: begin
                timer_d = '0;
                if (cmd_ready) begin
                    // Handshake frees the slot; a same-cycle byte is seen as an idle byte.
                    state_d = S_IDLE;
                    if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                        state_d   = S_OPC;
                        payload_d = '0;
                        idx_d     = '0;
                    end
                end else if (rx_valid) begin
                    err_ovr_d = 1'b1;
                end
            end

            default: begin
                // In-frame states: a byte always beats the timeout on the same cycle.
                if (rx_valid) begin
                    timer_d = '0;
                    case (state_q)
                        S_OPC: begin
                            opcode_d = rx_byte;
                            xor_d    = rx_byte;
                            if (LEGACY_SHORT && (rx_byte < 8'h10)) begin
                                len_d   = '0;
                                state_d = S_HOLD;
                            end else begin
                                state_d = S_LEN;
                            end
                        end
                        S_LEN: begin
                            if (rx_byte > 8'(MAX_PAYLOAD)) begin
                                err_len_d = 1'b1;
                                state_d   = S_IDLE;
                            end else begin
                                len_d   = LEN_W'(rx_byte);
                                xor_d   = xor_q ^ rx_byte;
                                state_d = (rx_byte == 8'h00) ? S_CHK : S_PAY;
                            end
                        end
                        S_PAY: begin
                            for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
                                if (idx_q == LEN_W'(i)) begin
                                    payload_d[8*i +: 8] = rx_byte;
                                end
                            end
                            xor_d = xor_q ^ rx_byte;
                            idx_d = idx_q + LEN_W'(1);
                            if (idx_q == (len_q - LEN_W'(1))) begin
                                state_d = S_CHK;
                            end
                        end
                        S_CHK: begin
                            if (rx_byte == xor_q) begin
                                state_d = S_HOLD;
                            end else begin
                                err_chk_d = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else if (timer_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
                    err_tmo_d = 1'b1;
                    timer_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
        endcase
    end

    assign cmd_opcode  = opcode_q;
    assign cmd_len     = len_q;
    assign cmd_payload = payload_q;

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Self-checking bench for uart_cmd_frame_decoder: directed scenarios followed by
// random frames checked against a frame-level reference model.
module tb_uart_cmd_frame_decoder;

    localparam int unsigned MAXP  = 8;
    localparam int unsigned TMO   = 40;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned PL_W  = 8 * MAXP;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic [7:0]      rx_byte   = 8'h00;
    logic            rx_valid  = 1'b0;
    logic            cmd_ready = 1'b0;
    logic            cmd_valid;
    logic [7:0]      cmd_opcode;
    logic [LEN_W-1:0] cmd_len;
    logic [PL_W-1:0] cmd_payload;
    logic            err_checksum, err_length, err_timeout, err_overrun, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt_chk = 0, cnt_len = 0, cnt_tmo = 0, cnt_ovr = 0;
    int exp_chk = 0, exp_len = 0, exp_tmo = 0, exp_ovr = 0;

    always #5 clk = ~clk;

    uart_cmd_frame_decoder #(
        .SYNC_BYTE    (8'hFE),
        .MAX_PAYLOAD  (MAXP),
        .TIMEOUT_CLKS (TMO),
        .LEGACY_SHORT (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_len      (cmd_len),
        .cmd_payload  (cmd_payload),
        .err_checksum (err_checksum),
        .err_length   (err_length),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .busy         (busy)
    );

    // Count every error pulse seen over the whole run.
    always @(posedge clk) begin
        if (err_checksum) cnt_chk <= cnt_chk + 1;
        if (err_length)   cnt_len <= cnt_len + 1;
        if (err_timeout)  cnt_tmo <= cnt_tmo + 1;
        if (err_overrun)  cnt_ovr <= cnt_ovr + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input logic [7:0] op, input logic [7:0] ln,
                             input logic [63:0] pl);
        check({tag, "_valid"},   64'(cmd_valid),   64'd1);
        check({tag, "_opcode"},  64'(cmd_opcode),  64'(op));
        check({tag, "_len"},     64'(cmd_len),     64'(ln));
        check({tag, "_payload"}, 64'(cmd_payload), pl);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({cmd_valid, cmd_opcode, cmd_len, err_checksum, err_length,
                                    err_timeout, err_overrun, busy}), 64'd0);
        check({tag, "_payload"}, 64'(cmd_payload), 64'd0);
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(cmd_valid), 64'd0);
    endtask

    logic [7:0]  op, ln, chk, b;
    logic [63:0] pl;
    logic [7:0]  q[$];
    int          kind, ngarb, gap;

    initial begin
        // Reset state.
        tick();
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // T1: short form, hold stability, release.
        send(8'hFE);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_valid_early", 64'(cmd_valid), 64'd0);
        send(8'h00);
        check_cmd("t1", 8'h00, 8'h00, 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_cmd("t1_hold", 8'h00, 8'h00, 64'd0);
        end
        handshake("t1");
        check("t1_idle", 64'(busy), 64'd0);

        // T2: normal frame with payload.
        send(8'hFE); send(8'h21); send(8'h02); send(8'hAB); send(8'hCD);
        check("t2_valid_early", 64'(cmd_valid), 64'd0);
        send(8'h45);
        check_cmd("t2", 8'h21, 8'h02, 64'h0000_0000_0000_CDAB);
        check("t2_errs", 64'({err_checksum, err_length, err_timeout, err_overrun}), 64'd0);
        handshake("t2");

        // T3: bad checksum, then recovery.
        send(8'hFE); send(8'h21); send(8'h02); send(8'hAB); send(8'hCD); send(8'h46);
        exp_chk++;
        check("t3_err_chk", 64'(err_checksum), 64'd1);
        check("t3_no_valid", 64'(cmd_valid), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        tick();
        check("t3_pulse_end", 64'(err_checksum), 64'd0);
        send(8'hFE); send(8'h00);
        check_cmd("t3_recover", 8'h00, 8'h00, 64'd0);
        handshake("t3");

        // T4: oversize length, then zero-length long frame.
        send(8'hFE); send(8'h21); send(8'h09);
        exp_len++;
        check("t4_err_len", 64'(err_length), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        send(8'hFE); send(8'h21); send(8'h00); send(8'h21);
        check_cmd("t4_len0", 8'h21, 8'h00, 64'd0);
        handshake("t4");

        // T5: inter-byte timeout exactly TMO clocks after the last byte.
        send(8'hFE); send(8'h21); send(8'h02); send(8'hAB);
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        check("t5_no_tmo_yet", 64'(err_timeout), 64'd0);
        check("t5_busy_yet", 64'(busy), 64'd1);
        tick();
        exp_tmo++;
        check("t5_tmo", 64'(err_timeout), 64'd1);
        check("t5_idle", 64'(busy), 64'd0);
        // A byte on the final count is consumed and cancels the timeout.
        send(8'hFE); send(8'h21); send(8'h02); send(8'hAB);
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        send(8'hCD);
        check("t5_late_no_tmo", 64'(err_timeout), 64'd0);
        check("t5_late_busy", 64'(busy), 64'd1);
        send(8'h45);
        check_cmd("t5_late", 8'h21, 8'h02, 64'h0000_0000_0000_CDAB);
        handshake("t5");

        // T6: overrun while holding, same-cycle handshake with SYNC, reset mid-payload.
        send(8'hFE); send(8'h30); send(8'h01); send(8'h77); send(8'h46);
        check_cmd("t6_held", 8'h30, 8'h01, 64'h77);
        send(8'h5A);
        exp_ovr++;
        check("t6_overrun", 64'(err_overrun), 64'd1);
        check_cmd("t6_unchanged", 8'h30, 8'h01, 64'h77);
        handshake("t6");
        send(8'hFE); send(8'h00);
        cmd_ready = 1'b1;
        send(8'hFE);
        cmd_ready = 1'b0;
        check("t6_hs_sync_valid", 64'(cmd_valid), 64'd0);
        check("t6_hs_sync_busy", 64'(busy), 64'd1);
        check("t6_hs_sync_novr", 64'(err_overrun), 64'd0);
        send(8'h05);
        check_cmd("t6_hs_sync_cmd", 8'h05, 8'h00, 64'd0);
        handshake("t6_b");
        send(8'hFE); send(8'h21); send(8'h03); send(8'h11);
        rst_n = 1'b0;
        #2;
        check_all_zero("t6_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("t6_after_reset");
        send(8'hFE); send(8'h07);
        check_cmd("t6_post_reset", 8'h07, 8'h00, 64'd0);
        handshake("t6_c");

        // Random frames checked against the frame-level model.
        for (int f = 0; f < 80; f++) begin
            kind = int'($urandom_range(4, 0));
            q.delete();
            pl = 64'd0;
            if (kind == 4) begin
                ngarb = int'($urandom_range(3, 1));
                for (int g = 0; g < ngarb; g++) send(8'($urandom_range(253, 0)));
                check("rnd_garbage_idle", 64'(busy), 64'd0);
            end
            if (kind == 3) begin
                op = 8'($urandom_range(15, 0));
                ln = 8'h00;
                q.push_back(8'hFE); q.push_back(op);
            end else if (kind == 2) begin
                op = 8'($urandom_range(255, 16));
                ln = 8'($urandom_range(255, 9));
                q.push_back(8'hFE); q.push_back(op); q.push_back(ln);
            end else begin
                op  = 8'($urandom_range(255, 16));
                ln  = 8'($urandom_range(MAXP, 0));
                chk = op ^ ln;
                q.push_back(8'hFE); q.push_back(op); q.push_back(ln);
                for (int i = 0; i < int'(ln); i++) begin
                    b = 8'($urandom);
                    pl[8*i +: 8] = b;
                    chk = chk ^ b;
                    q.push_back(b);
                end
                if (kind == 1) chk = chk ^ 8'($urandom_range(255, 1));
                q.push_back(chk);
            end
            for (int i = 0; i < q.size(); i++) begin
                if (i > 0) begin
                    gap = int'($urandom_range(4, 0));
                    for (int g = 0; g < gap; g++) tick();
                end
                send(q[i]);
            end
            if (kind == 1) begin
                exp_chk++;
                check("rnd_err_chk", 64'(err_checksum), 64'd1);
                check("rnd_chk_no_valid", 64'(cmd_valid), 64'd0);
            end else if (kind == 2) begin
                exp_len++;
                check("rnd_err_len", 64'(err_length), 64'd1);
                check("rnd_len_idle", 64'(busy), 64'd0);
            end else begin
                check_cmd("rnd_cmd", op, ln, pl);
                if ($urandom_range(3, 0) == 0) begin
                    send(8'($urandom));
                    exp_ovr++;
                    check("rnd_overrun", 64'(err_overrun), 64'd1);
                    check_cmd("rnd_after_ovr", op, ln, pl);
                end
                gap = int'($urandom_range(3, 0));
                for (int g = 0; g < gap; g++) tick();
                handshake("rnd");
            end
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) tick();
        end

        tick();
        tick();
        check("total_err_checksum", 64'(cnt_chk), 64'(exp_chk));
        check("total_err_length",   64'(cnt_len), 64'(exp_len));
        check("total_err_timeout",  64'(cnt_tmo), 64'(exp_tmo));
        check("total_err_overrun",  64'(cnt_ovr), 64'(exp_ovr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
